// File: rtl/sram_burst_reader_if.sv
// sram_burst_reader_if
// Bundles the three buses of the SRAM burst reader.
//   cmd_*  : burst command channel (start word address, word count).
//   sram_* : read port of the dual-port SRAM buffer (enable, address, data).
//   m_*    : output word stream towards the NPU datapath.
// Handshake rule for cmd_* and m_*: a transfer happens on a rising clock edge
// where valid and ready are both high. Once the producer raises valid, it
// holds valid and its payload unchanged until that transfer happens.
// Modports:
//   master : the reader itself (drives cmd_ready, sram_enb/addrb, m_*).
//   slave  : the surrounding logic (command source, SRAM, downstream sink).
interface sram_burst_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 13
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              sram_enb;
  logic [ADDR_W-1:0] sram_addrb;
  logic [DATA_W-1:0] sram_doutb;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, sram_doutb, m_ready,
    output cmd_ready, sram_enb, sram_addrb, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, sram_doutb, m_ready,
    input  cmd_ready, sram_enb, sram_addrb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sram_burst_reader.sv
// sram_burst_reader
// Reads a burst of consecutive words from the 4096 x 128 SRAM buffer and
// streams them out with full back-pressure at up to one word per cycle.
// The SRAM read data arrives one cycle after sram_enb. A small output FIFO
// absorbs that latency. Reads are only issued while the FIFO plus the read
// in flight leave room, so captured data never has to be dropped.
// Ports:
//   clk, rst  : single clock (also the SRAM clkb), async active-high reset.
//   bus       : sram_burst_reader_if.master (cmd_*, sram_*, m_* buses).
//   busy      : burst in progress (state != IDLE).
//   done      : one-cycle pulse when a burst completes (also for length 0).
//   dbg_state : current FSM state (0 IDLE, 1 RUN, 2 DRAIN).
// Optional (macro SRAM_BURST_READER_PERF_EN):
//   perf_busy_cyc, perf_stall_cyc, perf_bursts : saturating counters.
module sram_burst_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_burst_reader_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
`ifdef SRAM_BURST_READER_PERF_EN
  ,
  output logic [31:0]                perf_busy_cyc,
  output logic [31:0]                perf_stall_cyc,
  output logic [15:0]                perf_bursts
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;    // next address to read
  logic [ADDR_W-1:0] addr_hold;  // last address read, shown while idle
  logic [LEN_W-1:0]  issue_cnt;  // reads still to issue
  logic [LEN_W-1:0]  beat_cnt;   // beats still to deliver
  logic              in_flight;  // a read was issued last cycle

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;

  logic cmd_hs, start, issue, push, pop, last_pop, done_set;
  logic credit_ok, fifo_full, fifo_empty;

  assign cmd_hs     = bus.cmd_valid & bus.cmd_ready;
  assign start      = cmd_hs & (bus.cmd_len != '0);
  assign push       = in_flight;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign pop        = ~fifo_empty & bus.m_ready;
  assign last_pop   = pop & (beat_cnt == LEN_W'(1));
  assign done_set   = (cmd_hs & (bus.cmd_len == '0)) | last_pop;
  // Space must exist for every word already captured or still in flight.
  assign credit_ok  = (32'(fifo_cnt) + 32'(in_flight)) < 32'(FIFO_DEPTH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && issue_cnt == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.cmd_ready = 1'b0;
    issue         = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      RUN:     issue = (issue_cnt != '0) && credit_ok;
      default: ;
    endcase
  end

  assign bus.sram_enb   = issue;
  assign bus.sram_addrb = issue ? rd_addr : addr_hold;
  assign bus.m_valid    = ~fifo_empty;
  assign bus.m_data     = fifo_mem[rd_ptr];
  assign bus.m_last     = ~fifo_empty & (beat_cnt == LEN_W'(1));
  assign dbg_state      = state;

  // Burst counters, read capture flag and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      addr_hold <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      in_flight <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_flight <= issue;
      done      <= done_set;
      if (start) begin
        rd_addr   <= bus.cmd_addr;
        issue_cnt <= bus.cmd_len;
        beat_cnt  <= bus.cmd_len;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + ADDR_W'(1);  // wraps 4095 -> 0
          addr_hold <= rd_addr;
          issue_cnt <= issue_cnt - LEN_W'(1);
        end
        if (pop) beat_cnt <= beat_cnt - LEN_W'(1);
      end
    end
  end

  // Output FIFO; capture ignores m_ready, credit keeps it from overflowing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.sram_doutb;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full))
    else $error("sram_burst_reader: capture into a full output buffer");
`endif

`ifdef SRAM_BURST_READER_PERF_EN
  // Busy/stall counters restart with each command; the burst count only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
      perf_bursts    <= '0;
    end else begin
      if (cmd_hs) begin
        perf_busy_cyc  <= '0;
        perf_stall_cyc <= '0;
      end else begin
        if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
        if (bus.m_valid && !bus.m_ready && perf_stall_cyc != '1)
          perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if (done_set && perf_bursts != '1) perf_bursts <= perf_bursts + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 13;
  typedef logic [DATA_W:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       busy, done;
  logic [1:0] dbg_state;
`ifdef SRAM_BURST_READER_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
  logic [15:0] perf_bursts;
`endif

  sram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
`ifdef SRAM_BURST_READER_PERF_EN
    ,
    .perf_busy_cyc(perf_busy_cyc),
    .perf_stall_cyc(perf_stall_cyc),
    .perf_bursts(perf_bursts)
`endif
  );

  // SRAM model: word[i] = i, registered read
  logic [DATA_W-1:0] sram_mem [4096];
  initial for (int i = 0; i < 4096; i++) sram_mem[i] = DATA_W'(i);
  always @(posedge clk) if (bus.sram_enb) bus.sram_doutb <= sram_mem[bus.sram_addrb];

  // ---------------- scoreboard state ----------------
  vec_t              exp_q[$];       // {last, data}
  logic [ADDR_W-1:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- driver tasks ----------------
  int   ready_mode   = 0;   // 0: always ready, 1: 1-0-0-1 pattern, 2: manual_ready
  logic manual_ready = 1'b1;
  logic [3:0] ready_pat = 4'b1001;
  logic [1:0] ready_ph  = 2'd0;

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) bus.m_ready = 1'b1;
      else if (ready_mode == 1) begin
        bus.m_ready = ready_pat[ready_ph];
        ready_ph++;
      end else bus.m_ready = manual_ready;
    end
  end

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                          input bit push_exp);
    int n = 0;
    logic [ADDR_W-1:0] ad;
    if (push_exp) begin
      for (int i = 0; i < int'(len); i++) begin
        ad = a + ADDR_W'(i);
        exp_addr_q.push_back(ad);
        exp_q.push_back({(i == int'(len) - 1), DATA_W'(ad)});
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) flag("cmd_accept_timeout");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) flag("burst_timeout");
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  logic              mon_done_exp = 1'b0;
  logic              mon_nxt_done;
  int                mon_out = 0;    // reads issued but not yet delivered
  int                mon_pops = 0;
  int                mon_busy_cnt = 0;
  logic              mon_held = 1'b0;
  logic [DATA_W-1:0] mon_held_data;
  logic              mon_held_last;
  vec_t              mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_done_exp = 1'b0;
        mon_out      = 0;
        mon_held     = 1'b0;
      end else begin
        check("done", vec_t'(done), vec_t'(mon_done_exp));
        if (mon_done_exp) check("busy_at_done", vec_t'(busy), vec_t'(0));
        mon_nxt_done = 1'b0;
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (bus.cmd_len == '0) mon_nxt_done = 1'b1;
          mon_busy_cnt = 0;
        end
        if (busy) mon_busy_cnt++;
        if (bus.sram_enb) begin
          check("credit", vec_t'(mon_out < 4), vec_t'(1));
          if (exp_addr_q.size() == 0) flag("unexpected_sram_read");
          else check("sram_addrb", vec_t'(bus.sram_addrb), vec_t'(exp_addr_q.pop_front()));
        end
        if (mon_held) begin
          check("stall_valid", vec_t'(bus.m_valid), vec_t'(1));
          check("stall_data", vec_t'(bus.m_data), vec_t'(mon_held_data));
          check("stall_last", vec_t'(bus.m_last), vec_t'(mon_held_last));
        end
        mon_held      = bus.m_valid && !bus.m_ready;
        mon_held_data = bus.m_data;
        mon_held_last = bus.m_last;
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) flag("unexpected_beat");
          else begin
            mon_e = exp_q.pop_front();
            check("m_data", vec_t'(bus.m_data), vec_t'(mon_e[DATA_W-1:0]));
            check("m_last", vec_t'(bus.m_last), vec_t'(mon_e[DATA_W]));
            if (mon_e[DATA_W]) mon_nxt_done = 1'b1;
          end
          mon_pops++;
        end
        mon_out = mon_out + (bus.sram_enb ? 1 : 0) - ((bus.m_valid && bus.m_ready) ? 1 : 0);
        mon_done_exp = mon_nxt_done;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [ADDR_W-1:0] wrap_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  initial begin
    int n;
    int base;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_cmd_ready", vec_t'(bus.cmd_ready), vec_t'(1));
    check("rst_sram_enb", vec_t'(bus.sram_enb), vec_t'(0));
    check("rst_sram_addrb", vec_t'(bus.sram_addrb), vec_t'(0));
    check("rst_m_valid", vec_t'(bus.m_valid), vec_t'(0));
    check("rst_m_data", vec_t'(bus.m_data), vec_t'(0));
    check("rst_m_last", vec_t'(bus.m_last), vec_t'(0));
    check("rst_busy", vec_t'(busy), vec_t'(0));
    check("rst_done", vec_t'(done), vec_t'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst: 0x010 x 8, first beat 3 cycles after handshake, done at cycle 11
    send_cmd(12'h010, 13'd8, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_valid && n < 20);
    check("first_valid_latency", vec_t'(n), vec_t'(3));
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_cycle", vec_t'(n), vec_t'(11));
    wait_idle(100);

    // Wrap-around: 0xFFE x 4 -> FFE, FFF, 000, 001
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(wrap_addr[i]);
      exp_q.push_back({(i == 3), DATA_W'(wrap_addr[i])});
    end
    send_cmd(12'hFFE, 13'd4, 1'b0);
    wait_idle(100);

    // Back-pressure: 16 words with ready pattern 1-0-0-1
    ready_mode = 1;
    send_cmd(12'h300, 13'd16, 1'b1);
    wait_idle(300);
    ready_mode = 0;

    // Zero length: no reads, no beats, done next cycle, cmd_ready stays high
    send_cmd(12'h123, 13'd0, 1'b1);
    check("zero_cmd_ready", vec_t'(bus.cmd_ready), vec_t'(1));
    check("zero_busy", vec_t'(busy), vec_t'(0));
    @(posedge clk); #1;
    check("zero_cmd_ready2", vec_t'(bus.cmd_ready), vec_t'(1));
    wait_idle(20);

    // Reset after 5 of 20 beats
    base = mon_pops;
    send_cmd(12'h040, 13'd20, 1'b1);
    n = 0;
    while (mon_pops < base + 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) flag("mid_burst_timeout");
    check("beats_before_rst", vec_t'(mon_pops - base), vec_t'(5));
    rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    #1;
    check("midrst_m_valid", vec_t'(bus.m_valid), vec_t'(0));
    check("midrst_busy", vec_t'(busy), vec_t'(0));
    check("midrst_sram_enb", vec_t'(bus.sram_enb), vec_t'(0));
    repeat (2) @(posedge clk);
    #1;
    check("midrst_done", vec_t'(done), vec_t'(0));
    rst = 1'b0;
    send_cmd(12'h100, 13'd2, 1'b1);
    wait_idle(50);

`ifdef SRAM_BURST_READER_PERF_EN
    // Perf: after reset, 10 words with exactly 3 stall cycles
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ready_mode   = 2;
    manual_ready = 1'b0;
    send_cmd(12'h200, 13'd10, 1'b1);
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    manual_ready = 1'b1;
    wait_idle(100);
    ready_mode = 0;
    check("perf_stall_cyc", vec_t'(perf_stall_cyc), vec_t'(3));
    check("perf_bursts", vec_t'(perf_bursts), vec_t'(1));
    check("perf_busy_cyc", vec_t'(perf_busy_cyc), vec_t'(mon_busy_cnt));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", vec_t'(exp_q.size()), vec_t'(0));
    check("exp_addr_q_drained", vec_t'(exp_addr_q.size()), vec_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
